// File: rtl/mem_test_pkg.sv
// Shared definitions for the memory BIST controller: FSM state encoding
// and the test-pattern function used by both generator and comparator.
package mem_test_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } bist_state_e;

  localparam logic [3:0] ERR_CNT_MAX = 4'd15;

  // Callers truncate to their data width; the low bits are (addr*2) mod 2^DW
  // and their inverse on the second pass.
  function automatic logic [31:0] pat_fn(input logic [31:0] addr, input logic pass);
    logic [31:0] p;
    p = addr << 1;
    return pass ? ~p : p;
  endfunction

endpackage

// File: rtl/mem_pat_gen.sv
// Address counter with test-pattern lookup for the BIST controller.
module mem_pat_gen
  import mem_test_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          step,
  input  logic          pass,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] pattern
);

  logic [AW-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (clr) begin
      addr_d = '0;
    end else if (step) begin
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  // Pattern for the address loaded on the next edge, so the parent can
  // register write data in step with the address.
  assign pattern = DW'(pat_fn(32'(addr_d), pass));

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-style memory BIST: write/read/compare with a true then an inverted
// pattern, reporting a sticky error flag, first failing address and count.
module mem_bist_ctrl
  import mem_test_pkg::*;
#(
  parameter int DW    = 4,
  parameter int AW    = 4,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] err_addr,
  output logic [3:0]    err_count,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  bist_state_e   state_q, state_d;
  logic          pass_q, pass_d;
  logic [AW-1:0] addr;
  logic [DW-1:0] pat_next;
  logic          last, step, clr;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic [3:0]    err_count_q, err_count_d;
  logic          mem_wen_q, mem_wen_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cmp_valid_q, cmp_valid_d;
  logic [AW-1:0] cmp_addr_q, cmp_addr_d;
  logic [DW-1:0] cmp_exp_q, cmp_exp_d;
  logic          mismatch;

  always_comb begin
    last = (addr == AW'(DEPTH - 1));
    step = ((state_q == WRITE) || (state_q == READ)) && !last;
    clr  = !step;
  end

  mem_pat_gen #(
    .AW(AW),
    .DW(DW)
  ) u_pat_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .step   (step),
    .pass   (pass_d),
    .addr   (addr),
    .pattern(pat_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WRITE;
          pass_d  = 1'b0;
        end
      end
      WRITE: if (last) state_d = READ;
      READ:  if (last) state_d = DRAIN;
      DRAIN: begin
        if (!pass_q) begin
          state_d = WRITE;
          pass_d  = 1'b1;
        end else begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values; compare runs one cycle
  // behind the address to line up with the memory's read latency.
  always_comb begin
    busy_d      = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
    done_d      = (state_d == FIN);
    mem_wen_d   = (state_d == WRITE);
    mem_wdata_d = mem_wen_d ? pat_next : '0;

    cmp_valid_d = (state_q == READ);
    cmp_addr_d  = addr;
    cmp_exp_d   = DW'(pat_fn(32'(addr), pass_q));
    mismatch    = cmp_valid_q && (mem_rdata != cmp_exp_q);

    error_d     = error_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    if ((state_q == IDLE) && start) begin
      error_d     = 1'b0;
      err_addr_d  = '0;
      err_count_d = '0;
    end else if (mismatch) begin
      error_d = 1'b1;
      if (!error_q) err_addr_d = cmp_addr_q;
      if (err_count_q != ERR_CNT_MAX) err_count_d = err_count_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_exp_q   <= cmp_exp_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = addr;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench: BIST controller against an 8x4 one-cycle-read memory with
// injectable stuck-at and bit-flip faults.
module tb_mem_bist_ctrl;

  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done, error, mem_wen;
  logic [AW-1:0] err_addr, mem_addr;
  logic [3:0]    err_count;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem  [8];
  logic [DW-1:0] sa0  [8];
  logic [DW-1:0] sa1  [8];
  logic [DW-1:0] flip [8];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_bist_ctrl #(
    .DW(DW),
    .AW(AW),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_addr (err_addr),
    .err_count(err_count),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr[2:0]] <= mem_wdata;
    mem_rdata <= ((mem[mem_addr[2:0]] & ~sa0[mem_addr[2:0]]) | sa1[mem_addr[2:0]])
                 ^ flip[mem_addr[2:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 8; i++) begin
      sa0[i]  = '0;
      sa1[i]  = '0;
      flip[i] = '0;
    end
  endtask

  // One run from a start pulse; extra start pulses at busy cycles sa/sb.
  task automatic do_run(input int sa, input int sb, output int busy_cnt,
                        output int done_cnt, output int done_at,
                        output int stream_bad, output logic [8:0] first_err);
    logic          ewen;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    int            k, ps;
    busy_cnt = 0; done_cnt = 0; done_at = -1; stream_bad = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    first_err = {error, err_addr, err_count};
    for (int c = 1; c <= 60; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      k  = (c - 1) % 17;
      ps = (c - 1) / 17;
      ewen = 1'b0; eaddr = '0; ewd = '0;
      if (k < 8) begin
        ewen  = 1'b1;
        eaddr = 4'(k);
        ewd   = 4'(2 * k);
        if (ps == 1) ewd = ~ewd;
      end else if (k < 16) begin
        eaddr = 4'(k - 8);
      end
      if (c <= 34) begin
        if (mem_wen !== ewen || mem_addr !== eaddr || mem_wdata !== ewd) stream_bad++;
      end else begin
        if (mem_wen !== 1'b0 || mem_wdata !== 4'h0) stream_bad++;
      end
      start = (c == sa) || (c == sb);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic check_run(input string name, input int sa, input int sb,
                           input logic exp_err, input logic [3:0] exp_addr,
                           input logic [3:0] exp_cnt);
    int bc, dc, da, sbad;
    logic [8:0] fe;
    do_run(sa, sb, bc, dc, da, sbad, fe);
    tests++;
    if (bc !== 34) begin fails++; $display("FAIL %s_busy_cycles: got %0d expected 34", name, bc); end
    tests++;
    if (dc !== 1 || da !== 35) begin
      fails++; $display("FAIL %s_done: got %0d pulses at cycle %0d expected 1 at cycle 35", name, dc, da);
    end
    tests++;
    if (sbad !== 0) begin fails++; $display("FAIL %s_mem_stream: got %0d bad cycles expected 0", name, sbad); end
    tests++;
    if (fe !== 9'h000) begin fails++; $display("FAIL %s_err_clear_at_start: got %h expected 000", name, fe); end
    tests++;
    if ({error, err_addr, err_count} !== {exp_err, exp_addr, exp_cnt}) begin
      fails++;
      $display("FAIL %s_result: got err=%b addr=%0d cnt=%0d expected err=%b addr=%0d cnt=%0d",
               name, error, err_addr, err_count, exp_err, exp_addr, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    tick();
    tests++;
    if ({busy, done, error, err_addr, err_count, mem_wen, mem_addr, mem_wdata} !== 20'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 00000",
               {busy, done, error, err_addr, err_count, mem_wen, mem_addr, mem_wdata});
    end
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_start_ignored: got busy=%b expected 0", busy); end
  endtask

  task automatic test_clean_run();
    clear_faults();
    check_run("clean", -1, -1, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic test_stuck_at0();
    clear_faults();
    sa0[3] = 4'h1;
    check_run("sa0_addr3", -1, -1, 1'b1, 4'd3, 4'd1);
  endtask

  task automatic test_stuck_at1();
    clear_faults();
    sa1[1] = 4'h8;
    sa1[2] = 4'h8;
    check_run("sa1_addr1_2", -1, -1, 1'b1, 4'd1, 4'd2);
  endtask

  task automatic test_saturation();
    clear_faults();
    for (int i = 0; i < 8; i++) flip[i] = 4'h1;
    check_run("count_saturate", -1, -1, 1'b1, 4'd0, 4'd15);
  endtask

  task automatic test_start_ignored();
    clear_faults();
    check_run("start_midrun", 5, 20, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic test_reset_abort();
    int dc;
    clear_faults();
    sa1[0] = 4'h1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if ({busy, done, error, err_addr, err_count, mem_wen, mem_addr, mem_wdata} !== 20'h0) begin
      fails++;
      $display("FAIL abort_outputs: got %h expected 00000",
               {busy, done, error, err_addr, err_count, mem_wen, mem_addr, mem_wdata});
    end
    dc = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) dc++;
      tick();
    end
    tests++;
    if (dc !== 0) begin fails++; $display("FAIL abort_no_done: got %0d active cycles expected 0", dc); end
    clear_faults();
    check_run("after_abort", -1, -1, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic test_back_to_back();
    clear_faults();
    sa0[3] = 4'h1;
    check_run("faulty_first", -1, -1, 1'b1, 4'd3, 4'd1);
    clear_faults();
    check_run("clean_second", -1, -1, 1'b0, 4'd0, 4'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear_faults();
    for (int i = 0; i < 8; i++) mem[i] = '0;
    test_reset();
    test_clean_run();
    test_stuck_at0();
    test_stuck_at1();
    test_saturation();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
